// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM arbiter slice.
package sram_arb_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    // Explicit encodings keep the state values stable for legacy tools and
    // for anyone decoding the state register in a waveform.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        ACK  = 3'd5
    } state_t;

    typedef enum logic {
        CPU = 1'b0,
        DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side port bundle: one instance each for the CPU and the debug/loader port.
interface sram_arbiter_if;
    logic                             req;
    logic                             we;
    logic [sram_arb_pkg::ADDR_W-1:0]  addr;
    logic [sram_arb_pkg::DATA_W-1:0]  wdata;
    logic [sram_arb_pkg::DATA_W-1:0]  rdata;
    logic                             ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational grant, registered last owner.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset,
    input  logic   req_cpu,
    input  logic   req_dbg,
    input  logic   take,
    output logic   grant_vld,
    output owner_t grant
);

    owner_t last_owner;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant_vld = req_cpu | req_dbg;
        grant     = CPU;
        if (req_cpu && req_dbg)
            grant = (last_owner == CPU) ? DBG : CPU;
        else if (req_dbg)
            grant = DBG;
    end

    // Reset to DBG so the very first tie goes to the CPU.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            last_owner <= DBG;
        else if (take)
            last_owner <= grant;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port asynchronous SRAM arbiter: fixed 3-cycle read/write sequences,
// round-robin between the CPU and the debug/loader port.
module sram_arbiter
    import sram_arb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     cpu,
    sram_arbiter_if.slave     dbg,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              busy
);

    state_t              state, state_nxt;
    owner_t              owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_cpu_q, rdata_dbg_q;

    logic                grant_vld;
    owner_t              grant;
    logic                is_idle;
    logic                take;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign is_idle = (state == IDLE);
    // Requests are only looked at in IDLE; mid-transaction activity is ignored.
    assign take    = is_idle & grant_vld;

    rr_arb2 u_rr (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_cpu   (cpu.req),
        .req_dbg   (dbg.req),
        .take      (take),
        .grant_vld (grant_vld),
        .grant     (grant)
    );

    // Select the winning port's command fields.
    always_comb begin
        sel_we    = cpu.we;
        sel_addr  = cpu.addr;
        sel_wdata = cpu.wdata;
        if (grant == DBG) begin
            sel_we    = dbg.we;
            sel_addr  = dbg.addr;
            sel_wdata = dbg.wdata;
        end
    end

    // Next-state: both sequences are two access cycles followed by ACK.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = sel_we ? WR1 : RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = ACK;
            WR1:     state_nxt = WR2;
            WR2:     state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; Reset aborts any transaction without an ack.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Latch the granted command so the pads stay stable through ACK.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner_q <= CPU;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            owner_q <= grant;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // Capture read data at the RD2 -> ACK edge into the owner's register only.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata_cpu_q <= '0;
            rdata_dbg_q <= '0;
        end else if (state == RD2) begin
            if (owner_q == CPU) rdata_cpu_q <= sram_dq_in;
            else                rdata_dbg_q <= sram_dq_in;
        end
    end

    // Strobes decode straight from the state register, so OE and WE/dq_oe
    // are mutually exclusive by construction.
    assign Mem_CE      = is_idle;
    assign Mem_UB      = is_idle;
    assign Mem_LB      = is_idle;
    assign Mem_OE      = !((state == RD1) || (state == RD2));
    assign Mem_WE      = (state != WR1);
    assign sram_dq_oe  = (state == WR1) || (state == WR2);
    assign sram_addr   = addr_q;
    assign sram_dq_out = wdata_q;
    assign busy        = !is_idle;

    assign cpu.ack   = (state == ACK) && (owner_q == CPU);
    assign dbg.ack   = (state == ACK) && (owner_q == DBG);
    assign cpu.rdata = rdata_cpu_q;
    assign dbg.rdata = rdata_dbg_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table plus hand-written corner sequences.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, busy;

    sram_arbiter_if cpu_if();
    sram_arbiter_if dbg_if();

    sram_arbiter dut (
        .Clk(Clk), .Reset(Reset), .cpu(cpu_if), .dbg(dbg_if),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pad-safety invariants, sampled away from the active edge every cycle.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("oe_we_excl",   32'(!Mem_OE && !Mem_WE), 32'(0));
            chk("oe_dqoe_excl", 32'(!Mem_OE && sram_dq_oe), 32'(0));
        end
    end

    // Scoreboard: expected (owner, owner rdata) pushed at drive, popped at ack.
    typedef struct { bit port; logic [15:0] rdata; } exp_t;
    exp_t        sb[$];
    logic [15:0] mdl_rdata [2];

    task automatic push_exp(input bit port, input bit we, input logic [15:0] dq);
        exp_t e;
        if (!we) mdl_rdata[port] = dq;
        e.port  = port;
        e.rdata = mdl_rdata[port];
        sb.push_back(e);
    endtask

    task automatic check_ack(input int port);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'(1));
        end else begin
            e = sb.pop_front();
            chk("ack_port", 32'(port), 32'(e.port));
            chk("rdata", 32'(e.port ? dbg_if.rdata : cpu_if.rdata), 32'(e.rdata));
        end
    endtask

    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [19:0] a, input logic [15:0] d);
        if (port) begin
            dbg_if.req = req; dbg_if.we = we; dbg_if.addr = a; dbg_if.wdata = d;
        end else begin
            cpu_if.req = req; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = d;
        end
    endtask

    // Waits (bounded) for any ack; port = -1 on timeout, cyc = negedges waited.
    task automatic wait_ack(output int port, output int cyc);
        bit done = 0;
        port = -1;
        cyc  = 0;
        while (!done && cyc < 20) begin
            @(negedge Clk);
            cyc++;
            if (cpu_if.ack || dbg_if.ack) begin
                port = dbg_if.ack ? 1 : 0;
                chk("ack_onehot", 32'(cpu_if.ack & dbg_if.ack), 32'(0));
                done = 1;
            end
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] dq;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge Clk);
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        sram_dq_in = v.dq;
        mdl_rdata[v.port] = v.exp_rdata;
        e.port = v.port; e.rdata = v.exp_rdata;
        sb.push_back(e);
        for (int n = 1; n <= 3; n++) begin
            @(negedge Clk);
            chk("v_addr", 32'(sram_addr), 32'(v.addr));
            chk("v_ce",   32'(Mem_CE), 32'(0));
            chk("v_oe",   32'(Mem_OE), 32'((!v.we && n < 3) ? 0 : 1));
            chk("v_we",   32'(Mem_WE), 32'((v.we && n == 1) ? 0 : 1));
            chk("v_dqoe", 32'(sram_dq_oe), 32'(v.we && n < 3));
            chk("v_ack",  32'(v.port ? dbg_if.ack : cpu_if.ack), 32'(n == 3));
            chk("v_oack", 32'(v.port ? cpu_if.ack : dbg_if.ack), 32'(0));
            if (v.we) chk("v_dqout", 32'(sram_dq_out), 32'(v.wdata));
        end
        check_ack(v.port);
        set_port(v.port, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge Clk);
        chk("v_idle_busy", 32'(busy), 32'(0));
        chk("v_idle_ce",   32'(Mem_CE), 32'(1));
    endtask

    initial begin
        int p, c;
        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 20'h00100, wdata: 16'h0000, dq: 16'hBEEF, exp_rdata: 16'hBEEF};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 20'h0ABCD, wdata: 16'h1234, dq: 16'h5555, exp_rdata: 16'h0000};
        vecs[2] = '{port: 1'b1, we: 1'b0, addr: 20'hFFFFF, wdata: 16'h0000, dq: 16'hA5A5, exp_rdata: 16'hA5A5};
        vecs[3] = '{port: 1'b0, we: 1'b1, addr: 20'h00000, wdata: 16'hFFFF, dq: 16'h7777, exp_rdata: 16'hBEEF};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 20'h12345, wdata: 16'h0000, dq: 16'h0001, exp_rdata: 16'h0001};
        vecs[5] = '{port: 1'b1, we: 1'b1, addr: 20'h54321, wdata: 16'h0F0F, dq: 16'h0000, exp_rdata: 16'hA5A5};

        // Reset state
        Reset = 1'b1;
        set_port(0, 0, 0, 20'h0, 16'h0);
        set_port(1, 0, 0, 20'h0, 16'h0);
        sram_dq_in = 16'h0;
        mdl_rdata[0] = 16'h0;
        mdl_rdata[1] = 16'h0;
        repeat (2) @(negedge Clk);
        chk("rst_ce",    32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'(5'b11111));
        chk("rst_dqoe",  32'(sram_dq_oe), 32'(0));
        chk("rst_acks",  32'({cpu_if.ack, dbg_if.ack}), 32'(0));
        chk("rst_busy",  32'(busy), 32'(0));
        chk("rst_addr",  32'(sram_addr), 32'(0));
        chk("rst_dqout", 32'(sram_dq_out), 32'(0));
        chk("rst_rdata", 32'({cpu_if.rdata, dbg_if.rdata}), 32'(0));
        Reset = 1'b0;

        // Tie after reset: both held -> CPU, DBG, CPU
        @(negedge Clk);
        set_port(0, 1, 1, 20'h00011, 16'h1111);
        set_port(1, 1, 1, 20'h00022, 16'h2222);
        push_exp(0, 1, 16'h0);
        push_exp(1, 1, 16'h0);
        push_exp(0, 1, 16'h0);
        for (int k = 0; k < 3; k++) begin
            wait_ack(p, c);
            chk("tie_latency", 32'(c), 32'(k == 0 ? 3 : 4));
            chk("tie_addr", 32'(sram_addr), 32'(p == 1 ? 20'h00022 : 20'h00011));
            check_ack(p);
        end
        set_port(0, 0, 0, 20'h0, 16'h0);
        set_port(1, 0, 0, 20'h0, 16'h0);
        @(negedge Clk);
        chk("tie_idle", 32'(busy), 32'(0));

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // DBG request arriving during a CPU RD1 waits for the next IDLE
        @(negedge Clk);
        set_port(0, 1, 0, 20'h00200, 16'h0);
        sram_dq_in = 16'hC0DE;
        push_exp(0, 0, 16'hC0DE);
        @(negedge Clk);
        chk("mid_rd1_oe", 32'(Mem_OE), 32'(0));
        set_port(1, 1, 1, 20'h00333, 16'h3333);
        push_exp(1, 1, 16'h0);
        wait_ack(p, c);
        chk("mid_cpu_lat", 32'(c), 32'(2));
        chk("mid_cpu_addr", 32'(sram_addr), 32'(20'h00200));
        check_ack(p);
        set_port(0, 0, 0, 20'h0, 16'h0);
        wait_ack(p, c);
        chk("mid_dbg_lat", 32'(c), 32'(4));
        chk("mid_dbg_addr", 32'(sram_addr), 32'(20'h00333));
        chk("mid_dbg_dq", 32'(sram_dq_out), 32'(16'h3333));
        check_ack(p);
        chk("mid_cpu_keep", 32'(cpu_if.rdata), 32'(16'hC0DE));
        set_port(1, 0, 0, 20'h0, 16'h0);
        @(negedge Clk);

        // Held CPU request: a second identical read starts from the IDLE cycle
        set_port(0, 1, 0, 20'h00444, 16'h0);
        sram_dq_in = 16'h4444;
        push_exp(0, 0, 16'h4444);
        push_exp(0, 0, 16'h4444);
        wait_ack(p, c);
        chk("held_lat1", 32'(c), 32'(3));
        check_ack(p);
        wait_ack(p, c);
        chk("held_lat2", 32'(c), 32'(4));
        chk("held_addr", 32'(sram_addr), 32'(20'h00444));
        check_ack(p);
        set_port(0, 0, 0, 20'h0, 16'h0);
        @(negedge Clk);
        chk("held_idle", 32'(busy), 32'(0));

        // Reset in RD2 aborts with no ack and clears read data
        set_port(0, 1, 0, 20'h00555, 16'h0);
        sram_dq_in = 16'h5555;
        repeat (2) @(negedge Clk);
        chk("rd2_oe", 32'(Mem_OE), 32'(0));
        Reset = 1'b1;
        #1;
        chk("rrd2_strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'(5'b11111));
        chk("rrd2_busy",  32'(busy), 32'(0));
        chk("rrd2_rdata", 32'(cpu_if.rdata), 32'(0));
        set_port(0, 0, 0, 20'h0, 16'h0);
        mdl_rdata[0] = 16'h0;
        mdl_rdata[1] = 16'h0;
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            chk("rrd2_noack", 32'({cpu_if.ack, dbg_if.ack}), 32'(0));
        end
        chk("rrd2_rdata_end", 32'(cpu_if.rdata), 32'(mdl_rdata[0]));
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have ports: Clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have ports: Reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-004 SHALL have ports: cpu_we  in  1  1 = write, 0 = read.
REQ-005 SHALL have ports: cpu_addr  in  20  word address.
REQ-006 SHALL have ports: cpu_wdata  in  16  write data.
REQ-007 SHALL have ports: cpu_rdata  out  16  registered read data; holds until the next CPU read completes.
REQ-008 SHALL have ports: cpu_ack  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports: dbg_req, dbg_we, dbg_addr[19:0], dbg_wdata[15:0], dbg_rdata[15:0], dbg_ack; same meanings as the CPU port, for the debug/memory-loader port.
REQ-010 SHALL have ports: sram_addr  out  20  SRAM address.
REQ-011 SHALL have ports: sram_dq_out  out  16  write data to the pad.
REQ-012 SHALL have ports: sram_dq_oe  out  1  1 = drive the data pad.
REQ-013 SHALL have ports: sram_dq_in  in  16  read data from the pad.
REQ-014 SHALL have ports: Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.
REQ-015 SHALL have ports: busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, RD1, RD2, WR1, WR2, ACK.
REQ-017 SHALL sample cpu_req/dbg_req only in IDLE.
REQ-018 SHALL, on the IDLE clock edge, grant when exactly one requester is active.
REQ-019 SHALL, when both requesters are active in IDLE, grant the port not granted last (round-robin via a last_owner register).
REQ-020 SHALL, on grant, latch owner, we, addr and wdata; go to RD1 if we = 0, else WR1.
REQ-021 SHALL follow the read sequence RD1 -> RD2 -> ACK -> IDLE.
REQ-022 SHALL hold Mem_OE = 0 in RD1 and RD2.
REQ-023 SHALL capture sram_dq_in into the owner's rdata register at the RD2 -> ACK edge.
REQ-024 SHALL follow the write sequence WR1 -> WR2 -> ACK -> IDLE.
REQ-025 SHALL hold Mem_WE = 0 in WR1 only.
REQ-026 SHALL hold sram_dq_oe = 1 in WR1 and WR2 (WR2 provides data hold after the WE rising edge).
REQ-027 SHALL drive Mem_CE, Mem_UB and Mem_LB to 0 in all non-IDLE states and to 1 in IDLE.
REQ-028 SHALL never assert Mem_OE = 0 and Mem_WE = 0 simultaneously.
REQ-029 SHALL never assert Mem_OE = 0 while sram_dq_oe = 1.
REQ-030 SHALL hold sram_addr and sram_dq_out at the latched values from the grant edge through ACK.
REQ-031 SHALL assert the owner's ack in ACK only, for exactly 1 cycle; the other port's ack SHALL stay 0.
REQ-032 SHALL give a latency of 3 cycles from the grant edge to the ack cycle, for both reads and writes; rdata SHALL be valid in the ack cycle.
REQ-033 SHALL require the requester to drop req at the edge ending its ack cycle; a req still high in the following IDLE cycle SHALL be treated as a new transaction.
REQ-034 SHALL ignore changes to the losing or non-owning port's inputs during a transaction.
REQ-035 SHALL NOT change the previous latched transaction when a request is deasserted before grant.
REQ-036 SHALL hold rdata unchanged after a write.

Reset
REQ-037 SHALL, on Reset, immediately (asynchronously) enter IDLE.
REQ-038 SHALL reset all strobes to 1, sram_dq_oe to 0, both acks to 0, busy to 0, and sram_addr, sram_dq_out and both rdata registers to 0.
REQ-039 SHALL reset last_owner to DBG, so the first tie grants CPU.
REQ-040 SHALL discard any transaction in progress when Reset is asserted mid-operation, with no ack issued.

Structure
REQ-041 SHALL place in shared package sram_arb_pkg: the state enum, the owner enum {CPU, DBG}, ADDR_W = 20 and DATA_W = 16.
REQ-042 SHALL factor tie-break logic into one sub-module, rr_arb2 (2-input round-robin picker, combinational grant plus last_owner update).

Verification
REQ-043 SHALL cover a CPU read: cpu_req = 1, cpu_we = 0, addr 0x00100, sram_dq_in = 0xBEEF -> OE low for 2 cycles, cpu_ack on cycle 3, cpu_rdata = 0xBEEF.
REQ-044 SHALL cover a DBG write: addr 0x0ABCD, wdata 0x1234 -> WE low for 1 cycle, dq_oe high for 2 cycles, sram_dq_out = 0x1234, dbg_ack on cycle 3, OE stays 1.
REQ-045 SHALL cover tie after reset: both reqs high -> CPU granted first, then DBG; when both are held, grants alternate CPU, DBG, CPU.
REQ-046 SHALL cover mid-transaction stimulus: dbg_req rises during a CPU RD1 -> DBG is granted only at the IDLE after cpu_ack; CPU addr and data are unaffected.
REQ-047 SHALL cover Reset asserted in RD2 -> strobes go high the same cycle, no ack, cpu_rdata = 0.
REQ-048 SHALL cover a held request: cpu_req held high through ack -> a second identical read starts from the IDLE cycle; assert the OE/WE and OE/dq_oe exclusion invariants throughout.
